// File: rtl/jtframe_db15_scan.sv
// DB15 two-player adapter reader: scans the cascaded parallel-load shift registers,
// filters glitches across frames and publishes active-high joystick words with a strobe.
module jtframe_db15_scan #(
    parameter int DIV    = 8,
    parameter int GAP    = 4096,
    parameter int FILTER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        update
);
    localparam int MAXC = (GAP > DIV) ? GAP : DIV;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CLKLO, CLKHI, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   raw_q, raw_d, prev_q;
    logic [1:0]    sync_q;
    logic          jclk_q, jload_q, upd_q;
    logic [11:0]   joy1_q, joy2_q;
    logic          sd, phase_end, accept;

    assign sd = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        raw_d     = raw_q;
        phase_end = (cnt_q == DIV_LAST);
        case (state_q)
            IDLE: if (cnt_q == GAP_LAST) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: if (phase_end) begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: if (phase_end) begin
                state_d = CLKLO;
                cnt_d   = '0;
                idx_d   = '0;
            end
            // bit 0 is already on JOY_DATA after the load, so sample before the rising edge
            CLKLO: if (phase_end) begin
                raw_d[idx_q] = sd;
                state_d      = CLKHI;
                cnt_d        = '0;
            end
            CLKHI: if (phase_end) begin
                cnt_d = '0;
                if (idx_q == 5'd31) begin
                    state_d = COMMIT;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = CLKLO;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        accept = (FILTER == 0) || (raw_d == prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            raw_q   <= '1;
            prev_q  <= '1;
            sync_q  <= 2'b11;
            jclk_q  <= 1'b0;
            jload_q <= 1'b1;
            upd_q   <= 1'b0;
            joy1_q  <= '0;
            joy2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            raw_q   <= raw_d;
            sync_q  <= {sync_q[0], JOY_DATA};
            // pins decoded from the next state so they leave the flops glitch-free
            jclk_q  <= (state_d == CLKHI);
            jload_q <= (state_d != LOAD);
            upd_q   <= (state_d == COMMIT) && accept;
            if (state_q == COMMIT) begin
                prev_q <= raw_q;
                if (accept) begin
                    joy1_q <= ~raw_q[11:0];
                    joy2_q <= ~raw_q[27:16];
                end
            end
        end
    end

    assign JOY_CLK   = jclk_q;
    assign JOY_LOAD  = jload_q;
    assign update    = upd_q;
    assign joystick1 = {4'h0, joy1_q};
    assign joystick2 = {4'h0, joy2_q};

endmodule

// File: tb/tb_jtframe_db15_scan.sv
// Bench for jtframe_db15_scan: three instances (filtered, unfiltered, slow) driven by
// behavioural DB15 adapters and checked every cycle against a frame-level model.
module tb_jtframe_db15_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ab = 1'b1;
  logic        rst_c  = 1'b1;
  logic        jclk  [3];
  logic        jload [3];
  logic        jdata [3];
  logic        upd   [3];
  logic [15:0] j1    [3];
  logic [15:0] j2    [3];

  logic [31:0] pat   [3] = '{default: '0};
  logic [31:0] sr    [3] = '{default: '1};
  logic        cprev [3] = '{default: 1'b0};
  int          pend  [3] = '{default: 0};

  int tests = 0;
  int fails = 0;

  function automatic int divof(int k);  return (k == 2) ? 8 : 4;     endfunction
  function automatic int gapof(int k);  return (k == 2) ? 4096 : 16; endfunction
  function automatic int fltof(int k);  return (k == 1) ? 0 : 1;     endfunction
  function automatic int dlyof(int k);  return (k == 2) ? 1 : 0;     endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jtframe_db15_scan #(
      .DIV   (g == 2 ? 8 : 4),
      .GAP   (g == 2 ? 4096 : 16),
      .FILTER(g == 1 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (g == 2 ? rst_c : rst_ab),
      .JOY_DATA (jdata[g]),
      .JOY_CLK  (jclk[g]),
      .JOY_LOAD (jload[g]),
      .joystick1(j1[g]),
      .joystick2(j2[g]),
      .update   (upd[g])
    );
    assign jdata[g] = sr[g][0];
  end

  // adapter: 74HC165 chain, load while JOY_LOAD low, shift on JOY_CLK rise (optionally late)
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!jload[k]) begin
        sr[k]   <= ~pat[k];
        pend[k] <= 0;
      end else begin
        if (jclk[k] && !cprev[k]) begin
          if (dlyof(k) == 0) sr[k] <= {1'b1, sr[k][31:1]};
          else               pend[k] <= dlyof(k);
        end else if (pend[k] > 0) begin
          if (pend[k] == 1) sr[k] <= {1'b1, sr[k][31:1]};
          pend[k] <= pend[k] - 1;
        end
      end
      cprev[k] <= jclk[k];
    end
  end

  task automatic check(string nm, int k, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // frame-level model: cycle position within the frame period decides pins and commits
  int          n      [3];
  logic        live   [3] = '{default: 1'b0};
  logic [31:0] curf   [3];
  logic [31:0] prevf  [3];
  logic [31:0] stagef [3];
  logic        e_upd  [3];
  logic        e_load [3];
  logic        e_clk  [3];
  logic [15:0] e1     [3];
  logic [15:0] e2     [3];
  int          commits[3] = '{default: 0};
  int          m_dv, m_gp, m_per, m_t;

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_dv  = divof(k);
      m_gp  = gapof(k);
      m_per = 66 * m_dv + 1 + m_gp;
      if ((k == 2) ? rst_c : rst_ab) begin
        live[k] = 1'b1; n[k] = 1;
        e1[k] = '0; e2[k] = '0; e_upd[k] = 1'b0; e_load[k] = 1'b1; e_clk[k] = 1'b0;
        prevf[k] = '0; curf[k] = '0; stagef[k] = '0;
      end else if (live[k]) begin
        if (e_upd[k]) begin
          e1[k] = {4'h0, stagef[k][11:0]};
          e2[k] = {4'h0, stagef[k][27:16]};
        end
        n[k]++;
        m_t = (n[k] - 1) % m_per;
        if (m_t == m_gp) curf[k] = pat[k];
        e_load[k] = !(m_t >= m_gp && m_t < m_gp + m_dv);
        e_clk[k]  = (m_t >= m_gp + 2 * m_dv) && (m_t < m_per - 1) &&
                    (((m_t - m_gp - 2 * m_dv) / m_dv) % 2 == 1);
        e_upd[k]  = 1'b0;
        if (m_t == m_per - 1) begin
          e_upd[k]  = (fltof(k) == 0) || (curf[k] == prevf[k]);
          stagef[k] = curf[k];
          prevf[k]  = curf[k];
          commits[k]++;
        end
      end
    end
  end

  // per-cycle compare plus pin-timing monitors
  int   fallq [3][$];
  int   hiq   [3][$];
  int   loq   [3][$];
  int   hirun [3] = '{default: 0};
  int   lorun [3] = '{default: 0};
  logic lprev [3] = '{default: 1'b1};
  int   updc  [3] = '{default: 0};

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (live[k]) begin
        check("JOY_LOAD", k, longint'(jload[k]), longint'(e_load[k]));
        check("JOY_CLK",  k, longint'(jclk[k]),  longint'(e_clk[k]));
        check("update",   k, longint'(upd[k]),   longint'(e_upd[k]));
        check("joystick1", k, longint'(j1[k]), longint'(e1[k]));
        check("joystick2", k, longint'(j2[k]), longint'(e2[k]));
        if (!jload[k] && lprev[k]) fallq[k].push_back(n[k]);
        if (!jload[k]) lorun[k]++;
        else if (lorun[k] > 0) begin loq[k].push_back(lorun[k]); lorun[k] = 0; end
        if (jclk[k]) hirun[k]++;
        else if (hirun[k] > 0) begin hiq[k].push_back(hirun[k]); hirun[k] = 0; end
        updc[k] += int'(upd[k]);
        lprev[k] = jload[k];
      end
    end
  end

  task automatic after_commit(int k, int target);
    int g;
    g = 0;
    while (commits[k] < target && g < 20000) begin
      @(posedge clk); #2;
      g++;
    end
    check("commit_wait", k, longint'(commits[k] >= target), 1);
    @(posedge clk); #2;
  endtask

  localparam logic [31:0] F_A = 32'hF800_F0A5;
  localparam logic [31:0] F_G = 32'hF800_F0B5;

  int u0, bad, c;

  initial begin
    pat[2] = 32'h03C1_05A6;
    repeat (3) @(posedge clk);
    #2;
    rst_ab = 1'b0;
    rst_c  = 1'b0;

    // frame 1 all released; check pin timing of that frame
    after_commit(0, 1);
    check("first_load_fall_cycle", 0, fallq[0].size() > 0 ? fallq[0][0] : -1, 17);
    check("load_low_len", 0, loq[0].size() > 0 ? loq[0][0] : -1, 4);
    check("clk_pulses", 0, hiq[0].size(), 32);
    bad = 0;
    foreach (hiq[0][i]) if (hiq[0][i] != 4) bad++;
    check("clk_high_len_bad", 0, bad, 0);
    u0 = updc[0];
    pat[0] = F_A; pat[1] = F_A;

    after_commit(0, 2);
    check("second_load_fall_cycle", 0, fallq[0].size() > 1 ? fallq[0][1] : -1, 298);
    after_commit(0, 3);
    check("j1_after_two_frames", 0, j1[0], 16'h00A5);
    check("j2_after_two_frames", 0, j2[0], 16'h0800);
    check("updates_frames2_3", 0, updc[0] - u0, 1);

    // single-frame glitch on p1 bit 4
    u0 = updc[0];
    pat[0] = F_G; pat[1] = F_G;
    after_commit(0, 4);
    check("unfiltered_glitch_shown", 1, j1[1], 16'h00B5);
    check("filtered_glitch_hidden", 0, j1[0], 16'h00A5);
    pat[0] = F_A; pat[1] = F_A;
    after_commit(0, 5);
    check("unfiltered_glitch_gone", 1, j1[1], 16'h00A5);
    check("updates_glitch_frames", 0, updc[0] - u0, 0);

    // no adapter: data stuck high
    pat[0] = '0; pat[1] = '0;
    after_commit(0, 6);
    u0 = updc[0];
    after_commit(0, 10);
    check("stuck_high_j1", 0, j1[0], 0);
    check("stuck_high_j2", 0, j2[0], 0);
    check("stuck_high_updates", 0, updc[0] - u0, 4);

    // reset in the middle of a frame
    pat[0] = 32'h0000_0003; pat[1] = 32'h0000_0003;
    after_commit(0, 12);
    check("j1_before_reset", 0, j1[0], 16'h0003);
    repeat (189) @(posedge clk);
    #2;
    check("in_clkhi_bit20", 0, jclk[0], 1);
    rst_ab = 1'b1;
    @(posedge clk); #2;
    check("reset_j1", 0, j1[0], 0);
    check("reset_load", 0, jload[0], 1);
    check("reset_clk", 0, jclk[0], 0);
    rst_ab = 1'b0;
    c = 1;
    while (jload[0] && c < 100) begin
      @(posedge clk); #2;
      c++;
    end
    check("restart_load_fall_cycle", 0, c, 17);

    // slow instance: DIV=8, GAP=4096, data changes one cycle after each rise
    after_commit(2, 2);
    check("slow_j1", 2, j1[2], 16'h05A6);
    check("slow_j2", 2, j2[2], 16'h03C1);
    check("slow_period", 2, fallq[2].size() > 1 ? fallq[2][1] - fallq[2][0] : -1, 4625);
    check("slow_clk_high_len", 2, hiq[2].size() > 0 ? hiq[2][0] : -1, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
